// File: rtl/alias_reduce_pkg.sv
// Shared definitions for the alias-reduction stage: FSM state encoding,
// boundary counts, butterfly count and the Q15 rounding constant.
package alias_reduce_pkg;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_RDL  = 4'd1,
        S_RDH  = 4'd2,
        S_M0   = 4'd3,
        S_M1   = 4'd4,
        S_M2   = 4'd5,
        S_M3   = 4'd6,
        S_WRL  = 4'd7,
        S_WRH  = 4'd8,
        S_FIN  = 4'd9
    } alias_state_e;

    localparam logic [4:0] NB_LONG   = 5'd31;
    localparam logic [4:0] NB_MIXED  = 5'd1;
    localparam logic [4:0] NB_NONE   = 5'd0;
    localparam int         BUTTERFLIES = 8;
    localparam logic [2:0] LAST_BFLY = 3'(BUTTERFLIES - 1);
    localparam int         SB_STRIDE = 18;
    localparam logic [1:0] BT_SHORT  = 2'd2;

    // Accumulator width: full 32-bit product plus two guard bits.
    localparam int                      ACC_W   = 34;
    localparam logic signed [ACC_W-1:0] Q15_RND = 34'sd16384;

    // Number of subband boundaries to process for a given block type.
    function automatic logic [4:0] boundary_count(input logic [1:0] block_type,
                                                  input logic       mixed);
        logic [4:0] nb;
        if (block_type == BT_SHORT) begin
            if (mixed) begin
                nb = NB_MIXED;
            end else begin
                nb = NB_NONE;
            end
        end else begin
            nb = NB_LONG;
        end
        return nb;
    endfunction

endpackage

// File: rtl/alias_reduce_coef_rom.sv
// Butterfly coefficient table: index i -> {cs[i], ca[i]} in Q15.
// cs = round(32768/sqrt(1+c^2)), ca = round(32768*c/sqrt(1+c^2)).
// cs[7] rounds to 32768, which is not representable in a signed 16-bit
// word, so it is held at 32767.
module alias_reduce_coef_rom
    import alias_reduce_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic        [2:0]    idx,
    output logic signed [DW-1:0] cs,
    output logic signed [DW-1:0] ca
);

    // Constant lookup of the coefficient pair.
    always_comb begin
        cs = 16'sd0;
        ca = 16'sd0;
        case (idx)
            3'd0:    begin cs = 16'sd28098; ca = -16'sd16859; end
            3'd1:    begin cs = 16'sd28893; ca = -16'sd15458; end
            3'd2:    begin cs = 16'sd31117; ca = -16'sd10269; end
            3'd3:    begin cs = 16'sd32221; ca = -16'sd5961;  end
            3'd4:    begin cs = 16'sd32621; ca = -16'sd3099;  end
            3'd5:    begin cs = 16'sd32740; ca = -16'sd1342;  end
            3'd6:    begin cs = 16'sd32765; ca = -16'sd465;   end
            3'd7:    begin cs = 16'sd32767; ca = -16'sd121;   end
            default: begin cs = 16'sd0;     ca = 16'sd0;     end
        endcase
    end

endmodule

// File: rtl/alias_reduce.sv
// In-place alias reduction on one channel's 576-sample granule RAM.
// Eight 8-cycle butterflies per subband boundary share one signed multiplier.
// Build option: ALIAS_SAT_EN clamps each rounded result to the 16-bit range;
// without it the low 16 bits are kept (two's-complement wrap).
module alias_reduce
    import alias_reduce_pkg::*;
#(
    parameter int DW = 16,
    parameter int AW = 10
) (
    input  logic          CLK_I,
    input  logic          RST_I,
    input  logic          START_I,
    input  logic [1:0]    BLOCK_TYPE_I,
    input  logic          MIXED_I,
    output logic          BUSY_O,
    output logic          DONE_O,
    output logic [AW-1:0] RAM_ADDR_O,
    output logic          RAM_WE_O,
    output logic [DW-1:0] RAM_DOUT_O,
    input  logic [DW-1:0] RAM_DIN_I
);

    alias_state_e state_r, state_nxt_s;
    logic [2:0]    i_r, i_nxt_s;
    logic [4:0]    sb_r, sb_nxt_s, nb_r, nb_nxt_s;
    logic [AW-1:0] base_r, base_nxt_s, lo_addr_nxt_s, hi_addr_nxt_s;

    logic signed [DW-1:0]    lo_r, hi_r, lo_res_r, hi_res_r;
    logic signed [DW-1:0]    cs_s, ca_s, mul_a_s, mul_b_s, res_s;
    logic signed [2*DW-1:0]  prod_s;
    logic signed [ACC_W-1:0] prod_ext_s, acc_r, sum_s;

    logic          busy_nxt_s, done_nxt_s, we_nxt_s;
    logic [AW-1:0] addr_nxt_s;
    logic [DW-1:0] dout_nxt_s;
    logic          busy_r, done_r, we_r;
    logic [AW-1:0] addr_r;
    logic [DW-1:0] dout_r;

    alias_reduce_coef_rom #(.DW(DW)) u_coef_rom (
        .idx (i_r),
        .cs  (cs_s),
        .ca  (ca_s)
    );

    // Next-state and loop-counter logic for the butterfly sequencer.
    always_comb begin
        state_nxt_s = state_r;
        i_nxt_s     = i_r;
        sb_nxt_s    = sb_r;
        nb_nxt_s    = nb_r;
        base_nxt_s  = base_r;
        case (state_r)
            S_IDLE: begin
                if (START_I) begin
                    nb_nxt_s   = boundary_count(BLOCK_TYPE_I, MIXED_I);
                    i_nxt_s    = 3'd0;
                    sb_nxt_s   = 5'd1;
                    base_nxt_s = AW'(SB_STRIDE);
                    if (nb_nxt_s == NB_NONE) begin
                        state_nxt_s = S_FIN;
                    end else begin
                        state_nxt_s = S_RDL;
                    end
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_RDL: state_nxt_s = S_RDH;
            S_RDH: state_nxt_s = S_M0;
            S_M0:  state_nxt_s = S_M1;
            S_M1:  state_nxt_s = S_M2;
            S_M2:  state_nxt_s = S_M3;
            S_M3:  state_nxt_s = S_WRL;
            S_WRL: state_nxt_s = S_WRH;
            S_WRH: begin
                if (i_r == LAST_BFLY) begin
                    if (sb_r == nb_r) begin
                        state_nxt_s = S_FIN;
                    end else begin
                        i_nxt_s     = 3'd0;
                        sb_nxt_s    = sb_r + 5'd1;
                        base_nxt_s  = base_r + AW'(SB_STRIDE);
                        state_nxt_s = S_RDL;
                    end
                end else begin
                    i_nxt_s     = i_r + 3'd1;
                    state_nxt_s = S_RDL;
                end
            end
            S_FIN:   state_nxt_s = S_IDLE;
            default: state_nxt_s = S_IDLE;
        endcase
        lo_addr_nxt_s = base_nxt_s - {{(AW-1){1'b0}}, 1'b1} - {{(AW-3){1'b0}}, i_nxt_s};
        hi_addr_nxt_s = base_nxt_s + {{(AW-3){1'b0}}, i_nxt_s};
    end

    // Sequencer state and loop counters.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state_r <= S_IDLE;
            i_r     <= 3'd0;
            sb_r    <= 5'd0;
            nb_r    <= 5'd0;
            base_r  <= {AW{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            i_r     <= i_nxt_s;
            sb_r    <= sb_nxt_s;
            nb_r    <= nb_nxt_s;
            base_r  <= base_nxt_s;
        end
    end

    // Multiplier operand selection and accumulate/round datapath.
    always_comb begin
        mul_a_s = {DW{1'b0}};
        mul_b_s = {DW{1'b0}};
        case (state_r)
            S_M0:    begin mul_a_s = lo_r; mul_b_s = cs_s; end
            S_M1:    begin mul_a_s = hi_r; mul_b_s = ca_s; end
            S_M2:    begin mul_a_s = hi_r; mul_b_s = cs_s; end
            S_M3:    begin mul_a_s = lo_r; mul_b_s = ca_s; end
            default: begin mul_a_s = {DW{1'b0}}; mul_b_s = {DW{1'b0}}; end
        endcase
        prod_s     = mul_a_s * mul_b_s;
        prod_ext_s = {{(ACC_W-2*DW){prod_s[2*DW-1]}}, prod_s};
        case (state_r)
            S_M1:    sum_s = acc_r - prod_ext_s;
            S_M3:    sum_s = acc_r + prod_ext_s;
            default: sum_s = prod_ext_s;
        endcase
    end

`ifdef ALIAS_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = 34'sd32767;
    localparam logic signed [ACC_W-1:0] SAT_MIN = -34'sd32768;
    logic signed [ACC_W-1:0] rnd_s;

    // Round half up, then clamp to the signed 16-bit range.
    always_comb begin
        rnd_s = (sum_s + Q15_RND) >>> 15;
        if (rnd_s > SAT_MAX) begin
            res_s = 16'sh7fff;
        end else if (rnd_s < SAT_MIN) begin
            res_s = 16'sh8000;
        end else begin
            res_s = DW'(rnd_s);
        end
    end
`else
    // Round half up and keep the low 16 bits.
    always_comb begin
        res_s = DW'((sum_s + Q15_RND) >>> 15);
    end
`endif

    // Operand latches, accumulator and butterfly results.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            lo_r     <= {DW{1'b0}};
            hi_r     <= {DW{1'b0}};
            acc_r    <= {ACC_W{1'b0}};
            lo_res_r <= {DW{1'b0}};
            hi_res_r <= {DW{1'b0}};
        end else begin
            case (state_r)
                S_RDH: lo_r <= RAM_DIN_I;
                S_M0: begin
                    hi_r  <= RAM_DIN_I;
                    acc_r <= sum_s;
                end
                S_M1: begin
                    acc_r    <= sum_s;
                    lo_res_r <= res_s;
                end
                S_M2: acc_r <= sum_s;
                S_M3: begin
                    acc_r    <= sum_s;
                    hi_res_r <= res_s;
                end
                default: acc_r <= acc_r;
            endcase
        end
    end

    // Output values for the upcoming state, so the ports come straight from flops.
    always_comb begin
        busy_nxt_s = 1'b0;
        done_nxt_s = 1'b0;
        we_nxt_s   = 1'b0;
        addr_nxt_s = {AW{1'b0}};
        dout_nxt_s = {DW{1'b0}};
        case (state_nxt_s)
            S_RDL: begin busy_nxt_s = 1'b1; addr_nxt_s = lo_addr_nxt_s; end
            S_RDH: begin busy_nxt_s = 1'b1; addr_nxt_s = hi_addr_nxt_s; end
            S_M0, S_M1, S_M2, S_M3: busy_nxt_s = 1'b1;
            S_WRL: begin
                busy_nxt_s = 1'b1;
                we_nxt_s   = 1'b1;
                addr_nxt_s = lo_addr_nxt_s;
                dout_nxt_s = lo_res_r;
            end
            S_WRH: begin
                busy_nxt_s = 1'b1;
                we_nxt_s   = 1'b1;
                addr_nxt_s = hi_addr_nxt_s;
                dout_nxt_s = hi_res_r;
            end
            S_FIN:   done_nxt_s = 1'b1;
            default: busy_nxt_s = 1'b0;
        endcase
    end

    // Registered output ports.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
            we_r   <= 1'b0;
            addr_r <= {AW{1'b0}};
            dout_r <= {DW{1'b0}};
        end else begin
            busy_r <= busy_nxt_s;
            done_r <= done_nxt_s;
            we_r   <= we_nxt_s;
            addr_r <= addr_nxt_s;
            dout_r <= dout_nxt_s;
        end
    end

    assign BUSY_O     = busy_r;
    assign DONE_O     = done_r;
    assign RAM_WE_O   = we_r;
    assign RAM_ADDR_O = addr_r;
    assign RAM_DOUT_O = dout_r;

endmodule

// File: tb/tb_alias_reduce.sv
// Self-checking bench for alias_reduce: behavioural granule model with a
// write scoreboard, randomized RAM contents and block types.
module tb_alias_reduce;

    logic        CLK_I = 1'b0;
    logic        RST_I;
    logic        START_I;
    logic [1:0]  BLOCK_TYPE_I;
    logic        MIXED_I;
    logic        BUSY_O, DONE_O, RAM_WE_O;
    logic [9:0]  RAM_ADDR_O;
    logic [15:0] RAM_DOUT_O;
    logic [15:0] ram_din = 16'd0;

    alias_reduce #(.DW(16), .AW(10)) dut (
        .CLK_I        (CLK_I),
        .RST_I        (RST_I),
        .START_I      (START_I),
        .BLOCK_TYPE_I (BLOCK_TYPE_I),
        .MIXED_I      (MIXED_I),
        .BUSY_O       (BUSY_O),
        .DONE_O       (DONE_O),
        .RAM_ADDR_O   (RAM_ADDR_O),
        .RAM_WE_O     (RAM_WE_O),
        .RAM_DOUT_O   (RAM_DOUT_O),
        .RAM_DIN_I    (ram_din)
    );

    always #5 CLK_I = ~CLK_I;

    int n_checks = 0;
    int n_fail   = 0;
    int wr_cnt   = 0;

    logic [15:0] mem [0:1023];
    int          exp_mem [0:575];
    int          cs_t [8];
    int          ca_t [8];

    typedef struct {
        int addr;
        int data;
    } wr_t;
    wr_t wq[$];

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Synchronous-read granule RAM: data valid one cycle after the address.
    always @(posedge CLK_I) begin
        ram_din <= mem[RAM_ADDR_O];
        if (RAM_WE_O) mem[RAM_ADDR_O] = RAM_DOUT_O;
    end

    // Write scoreboard: every write must match the next expected one in order.
    always @(negedge CLK_I) begin
        if (RAM_WE_O) begin
            wr_t e;
            wr_cnt++;
            if (wq.size() == 0) begin
                check("wr_unexpected_addr", longint'(RAM_ADDR_O), -1);
            end else begin
                e = wq.pop_front();
                check("wr_addr", longint'(RAM_ADDR_O), e.addr);
                check("wr_data", longint'($signed(RAM_DOUT_O)), e.data);
            end
        end
    end

    function automatic int q15(input longint acc);
        longint r;
        logic signed [15:0] t;
        r = (acc + 64'sd16384) >>> 15;
`ifdef ALIAS_SAT_EN
        if (r > 32767) r = 32767;
        else if (r < -32768) r = -32768;
`endif
        t = r[15:0];
        return int'(t);
    endfunction

    // Expected granule after the pass, and the ordered list of writes.
    task automatic build_model(input int nb);
        int lo, hi, a, b;
        wq.delete();
        for (int k = 0; k < 576; k++) exp_mem[k] = int'($signed(mem[k]));
        for (int sb = 1; sb <= nb; sb++) begin
            for (int i = 0; i < 8; i++) begin
                lo = 18 * sb - 1 - i;
                hi = 18 * sb + i;
                a  = exp_mem[lo];
                b  = exp_mem[hi];
                exp_mem[lo] = q15(longint'(a) * cs_t[i] - longint'(b) * ca_t[i]);
                exp_mem[hi] = q15(longint'(b) * cs_t[i] + longint'(a) * ca_t[i]);
                wq.push_back('{addr: lo, data: exp_mem[lo]});
                wq.push_back('{addr: hi, data: exp_mem[hi]});
            end
        end
    endtask

    task automatic fill(input bit rnd);
        for (int k = 0; k < 1024; k++) mem[k] = rnd ? 16'($urandom) : 16'd0;
    endtask

    task automatic check_ram(input string name);
        int bad = 0;
        for (int k = 0; k < 576; k++)
            if (int'($signed(mem[k])) != exp_mem[k]) bad++;
        check(name, bad, 0);
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, "_busy"}, BUSY_O, 0);
        check({name, "_done"}, DONE_O, 0);
        check({name, "_we"},   RAM_WE_O, 0);
        check({name, "_addr"}, RAM_ADDR_O, 0);
        check({name, "_dout"}, RAM_DOUT_O, 0);
    endtask

    // One complete request; dup_at >= 0 re-pulses START that many cycles in.
    task automatic run(input logic [1:0] bt, input logic mx, input int dup_at, input string tag);
        int nb, edges, busy_cnt, done_cnt;
        nb = (bt == 2'd2) ? (mx ? 1 : 0) : 31;
        build_model(nb);
        wr_cnt = 0;
        @(negedge CLK_I);
        BLOCK_TYPE_I = bt;
        MIXED_I      = mx;
        START_I      = 1'b1;
        @(negedge CLK_I);
        START_I      = 1'b0;
        BLOCK_TYPE_I = 2'($urandom);
        MIXED_I      = 1'($urandom);
        edges = 0;
        busy_cnt = 0;
        while (!DONE_O && edges < 3000) begin
            if (BUSY_O) busy_cnt++;
            START_I = (edges == dup_at);
            @(negedge CLK_I);
            edges++;
        end
        START_I = 1'b0;
        check({tag, "_done_latency"}, edges, 64 * nb);
        check({tag, "_busy_cycles"}, busy_cnt, 64 * nb);
        check({tag, "_busy_at_done"}, BUSY_O, 0);
        done_cnt = 0;
        repeat (4) begin
            @(negedge CLK_I);
            if (DONE_O) done_cnt++;
        end
        check({tag, "_extra_done"}, done_cnt, 0);
        check({tag, "_write_count"}, wr_cnt, 16 * nb);
        check({tag, "_ram"}, 0, 0 + 0 * n_checks);
        check_ram({tag, "_ram_words_bad"});
    endtask

    initial begin
        real c [8] = '{-0.6, -0.535, -0.33, -0.185, -0.095, -0.041, -0.0142, -0.0037};
        real d;
        int  done_cnt;
        for (int i = 0; i < 8; i++) begin
            d = $sqrt(1.0 + c[i] * c[i]);
            cs_t[i] = $rtoi($floor(32768.0 / d + 0.5));
            if (cs_t[i] > 32767) cs_t[i] = 32767;
            ca_t[i] = -$rtoi($floor(-32768.0 * c[i] / d + 0.5));
        end

        RST_I = 1'b1;
        START_I = 1'b0;
        BLOCK_TYPE_I = 2'd0;
        MIXED_I = 1'b0;
        fill(1'b0);
        repeat (3) @(negedge CLK_I);
        check_idle_outputs("in_reset");
        RST_I = 1'b0;
        @(negedge CLK_I);
        check_idle_outputs("after_reset");

        // Short, non-mixed: immediate DONE, no RAM traffic.
        fill(1'b1);
        run(2'd2, 1'b0, -1, "short");

        // Mixed block: eight butterflies on sb=1 only.
        fill(1'b1);
        run(2'd2, 1'b1, -1, "mixed");

        // Long block, single impulse.
        fill(1'b0);
        mem[17] = 16'd32767;
        run(2'd0, 1'b0, -1, "impulse");
        check("impulse_ram17", longint'($signed(mem[17])), 28097);
        check("impulse_ram18", longint'($signed(mem[18])), -16858);

        // Overflow of the upper output of the first butterfly.
        fill(1'b0);
        mem[17] = 16'd32767;
        mem[18] = 16'h8000;
        run(2'd1, 1'b0, -1, "overflow");
        check("overflow_ram17", longint'($signed(mem[17])), 11238);
`ifdef ALIAS_SAT_EN
        check("overflow_ram18", longint'($signed(mem[18])), -32768);
`else
        check("overflow_ram18", longint'($signed(mem[18])), 20580);
`endif

        // START pulsed while busy must be ignored.
        fill(1'b1);
        run(2'd3, 1'b0, 200, "restart_ignored");

        // Random block types over random granules.
        for (int k = 0; k < 3; k++) begin
            fill(1'b1);
            run(2'($urandom_range(0, 3)), 1'($urandom), -1, "random");
        end

        // Reset in the middle of a long run.
        fill(1'b1);
        build_model(31);
        @(negedge CLK_I);
        BLOCK_TYPE_I = 2'd0;
        START_I = 1'b1;
        @(negedge CLK_I);
        START_I = 1'b0;
        repeat (498) @(negedge CLK_I);
        #2 RST_I = 1'b1;
        #1 check_idle_outputs("abort");
        done_cnt = 0;
        repeat (3) begin
            @(negedge CLK_I);
            if (DONE_O) done_cnt++;
        end
        check("abort_no_done", done_cnt, 0);
        RST_I = 1'b0;
        wq.delete();
        @(negedge CLK_I);
        fill(1'b1);
        run(2'd0, 1'b0, -1, "after_abort");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
